// File: rtl/scrypt_dispatch_controller.sv
`timescale 1ns/1ps
// Purpose : host command decoder, header RAM load sequencer and round-robin hash dispatcher.
// Latency : rx_notify -> load 1 cycle; last load -> start_hash 3 cycles; core_done -> nonce_ready 1 cycle.
// Backpr. : host must space bytes >= 4 cycles (bytes during LOAD/CHECK/INCR are dropped); jobs wait for an idle core.
//
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   rx_notify, rx_command      UART byte strobe and byte (command sampled in DECODE)
//   core_done, core_match      per-core completion pulse and match flag (qualified by done)
//   address, load              header RAM write address and one-cycle write strobe
//   start_hash                 one-hot core start pulse
//   nonce_ready, nonce_core    one-cycle match report and reporting core index
//   cores_busy                 per-core busy flags
//   cmd_error, timeout_err     one-cycle error pulses (bad command, WAIT idle timeout)
//
// Optional feature: define DISPATCH_TIMEOUT_EN to abandon a load after
// TIMEOUT_CYCLES idle cycles in WAIT. Without it WAIT holds forever and
// timeout_err is tied low.

module scrypt_dispatch_controller #(
    parameter int ADDR_W         = 7,
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CORE_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rx_notify,
    input  logic [7:0]           rx_command,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_match,
    output logic [ADDR_W-1:0]    address,
    output logic                 load,
    output logic [NUM_CORES-1:0] start_hash,
    output logic                 nonce_ready,
    output logic [CORE_W-1:0]    nonce_core,
    output logic [NUM_CORES-1:0] cores_busy,
    output logic                 cmd_error,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_INCR   = 3'd5,
        ST_HASH   = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      address_q, address_d;
    logic [ADDR_W-1:0]      final_address_q, final_address_d;
    logic                   hash_pending_q, hash_pending_d;
    logic [CORE_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0]   busy_q, busy_d;
    logic [NUM_CORES-1:0]   match_q, match_d;

    // ------------------------------------------------------------------
    // Command decode: one-hot region select -> start/end word address
    // ------------------------------------------------------------------
    logic                   cmd_valid;
    logic [ADDR_W-1:0]      region_start;
    logic [ADDR_W-1:0]      region_end;

    always_comb begin
        cmd_valid    = 1'b1;
        region_start = '0;
        region_end   = '0;
        case (rx_command)
            8'h01: begin region_start = ADDR_W'(0);  region_end = ADDR_W'(79); end
            8'h02: begin region_start = ADDR_W'(0);  region_end = ADDR_W'(3);  end
            8'h04: begin region_start = ADDR_W'(4);  region_end = ADDR_W'(7);  end
            8'h08: begin region_start = ADDR_W'(8);  region_end = ADDR_W'(11); end
            8'h10: begin region_start = ADDR_W'(12); region_end = ADDR_W'(43); end
            8'h20: begin region_start = ADDR_W'(44); region_end = ADDR_W'(75); end
            8'h40: begin region_start = ADDR_W'(76); region_end = ADDR_W'(79); end
            default: cmd_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // WAIT idle timeout (optional)
    // ------------------------------------------------------------------
    logic to_hit;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // A byte in the same cycle as expiry wins: the load proceeds.
    assign to_hit = (state_q == ST_WAIT) && !rx_notify &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    // Held at zero outside WAIT so the count starts from 0 on WAIT entry.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if ((state_q != ST_WAIT) || rx_notify) begin
            to_cnt_d = '0;
        end else if (!to_hit) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
    assign to_hit = 1'b0;
`endif

    assign timeout_err = to_hit;

    // ------------------------------------------------------------------
    // Data FSM
    // ------------------------------------------------------------------
    logic load_c;
    logic cmd_err_c;
    logic hash_req;

    always_comb begin
        state_d         = state_q;
        address_d       = address_q;
        final_address_d = final_address_q;
        load_c          = 1'b0;
        cmd_err_c       = 1'b0;
        hash_req        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_notify) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cmd_valid) begin
                    address_d       = region_start;
                    final_address_d = region_end;
                    state_d         = ST_WAIT;
                end else begin
                    // Bad command: keep the previous region untouched.
                    cmd_err_c = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (rx_notify) begin
                    state_d = ST_LOAD;
                end else if (to_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_c  = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (address_q == final_address_q) begin
                    state_d = ST_HASH;
                end else begin
                    state_d = ST_INCR;
                end
            end
            ST_INCR: begin
                address_d = address_q + ADDR_W'(1);
                state_d   = ST_WAIT;
            end
            ST_HASH: begin
                hash_req = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Dispatcher: first idle core at or after rr_ptr, cyclically
    // ------------------------------------------------------------------
    logic                 sel_found;
    logic [CORE_W-1:0]    sel_idx;
    logic                 dispatch;
    logic [NUM_CORES-1:0] start_c;
    int                   cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_CORES;
            if (!sel_found && !busy_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = CORE_W'(cand);
            end
        end
    end

    assign dispatch = hash_pending_q && sel_found;

    always_comb begin
        start_c = '0;
        if (dispatch) begin
            start_c[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (dispatch) begin
            rr_ptr_d = (sel_idx == CORE_W'(NUM_CORES - 1)) ? '0 : sel_idx + CORE_W'(1);
        end
    end

    // A new request landing while one is still pending merges into it; a
    // request arriving in the same cycle a pending job dispatches survives.
    assign hash_pending_d = (hash_pending_q && !dispatch) || hash_req;

    // ------------------------------------------------------------------
    // Per-core busy / match tracking and report serialiser
    // ------------------------------------------------------------------
    logic [NUM_CORES-1:0] done_ok;
    logic                 rep_vld;
    logic [CORE_W-1:0]    rep_idx;
    logic [NUM_CORES-1:0] rep_clr;

    // Completions from cores we never started are spurious and dropped.
    assign done_ok = core_done & busy_q;

    always_comb begin
        rep_vld = 1'b0;
        rep_idx = '0;
        rep_clr = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!rep_vld && match_q[i]) begin
                rep_vld    = 1'b1;
                rep_idx    = CORE_W'(i);
                rep_clr[i] = 1'b1;
            end
        end
    end

    // Starting and finishing cores are distinct, so set/clear never collide.
    assign busy_d  = (busy_q & ~done_ok) | start_c;
    assign match_d = (match_q & ~rep_clr) | (done_ok & core_match);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= ST_IDLE;
            address_q       <= '0;
            final_address_q <= '0;
            hash_pending_q  <= 1'b0;
            rr_ptr_q        <= '0;
            busy_q          <= '0;
            match_q         <= '0;
        end else begin
            state_q         <= state_d;
            address_q       <= address_d;
            final_address_q <= final_address_d;
            hash_pending_q  <= hash_pending_d;
            rr_ptr_q        <= rr_ptr_d;
            busy_q          <= busy_d;
            match_q         <= match_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign address     = address_q;
    assign load        = load_c;
    assign start_hash  = start_c;
    assign nonce_ready = rep_vld;
    assign nonce_core  = rep_idx;
    assign cores_busy  = busy_q;
    assign cmd_error   = cmd_err_c;

endmodule
